// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync-frame capture block.
// SYNC_FRAME_PARITY_EN extends each capture by one even-parity bit.
package sync_frame_pkg;

  localparam int DEF_PAYLOAD_W = 8;
  localparam int DEF_CNT_W     = 8;

  // Pattern recognised by the upstream detector; used by benches to build streams.
  localparam logic [4:0] SYNC_PATTERN = 5'b10110;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // Serial bits taken per frame, including the parity bit when enabled.
  function automatic int capture_len(input int payload_w);
`ifdef SYNC_FRAME_PARITY_EN
    return payload_w + 1;
`else
    return payload_w;
`endif
  endfunction

endpackage

// File: rtl/sync_frame_outreg.sv
// One-word output register with valid/ready handshake, drop detection
// and a wrapping count of delivered frames.
module sync_frame_outreg
  import sync_frame_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_data,
  input  logic                 load_perr,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 overflow,
  output logic                 parity_err
);

  logic [PAYLOAD_W-1:0] data_reg;
  logic                 valid_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 overflow_reg;
  logic                 perr_reg;
  logic                 can_load;

  // A pending word may be replaced only when it is being accepted this cycle.
  assign can_load = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      perr_reg     <= 1'b0;
    end else if (load && can_load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
      count_reg <= count_reg + CNT_W'(1);
      perr_reg  <= load_perr;
    end else begin
      if (load)
        overflow_reg <= 1'b1;
      else if (valid_reg && out_ready)
        valid_reg <= 1'b0;
    end
  end

  assign out_data    = data_reg;
  assign out_valid   = valid_reg;
  assign frame_count = count_reg;
  assign overflow    = overflow_reg;
  assign parity_err  = perr_reg;

endmodule

// File: rtl/sync_frame_capture.sv
// Captures the serial payload following a sync detection into a parallel word.
// Define SYNC_FRAME_PARITY_EN to capture and check a trailing even-parity bit.
module sync_frame_capture
  import sync_frame_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  input  logic                 detected,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 overflow,
  output logic                 parity_err
);

  localparam int LEN  = capture_len(PAYLOAD_W);
  localparam int BC_W = $clog2(LEN + 1);

  state_t               state_reg, state_next;
  logic [LEN-2:0]       shreg_reg;
  logic [BC_W-1:0]      bcnt_reg;
  logic [LEN-1:0]       word;
  logic                 last_bit;
  logic                 xfer;
  logic [PAYLOAD_W-1:0] payload;
  logic                 perr;

  // The full word includes the bit on the wire now, so the transfer happens
  // on the same edge that samples the last bit.
  assign word     = {shreg_reg, data};
  assign last_bit = (bcnt_reg == BC_W'(LEN - 1));

`ifdef SYNC_FRAME_PARITY_EN
  assign payload = word[LEN-1:1];
  assign perr    = ^word;
`else
  assign payload = word;
  assign perr    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (detected) state_next = CAPTURE;
      CAPTURE: if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == CAPTURE);
    xfer = (state_reg == CAPTURE) && last_bit;
  end

  // detected is deliberately ignored while capturing.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg <= '0;
      bcnt_reg  <= '0;
    end else if (state_reg == IDLE) begin
      if (detected) begin
        shreg_reg <= word[LEN-2:0];
        bcnt_reg  <= BC_W'(1);
      end
    end else begin
      shreg_reg <= word[LEN-2:0];
      bcnt_reg  <= last_bit ? '0 : bcnt_reg + BC_W'(1);
    end
  end

  sync_frame_outreg #(
    .PAYLOAD_W(PAYLOAD_W),
    .CNT_W    (CNT_W)
  ) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (xfer),
    .load_data  (payload),
    .load_perr  (perr),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_count(frame_count),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

endmodule

// File: tb/tb_sync_frame_capture.sv
// Self-checking bench for sync_frame_capture: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_sync_frame_capture;
  import sync_frame_pkg::*;

  localparam int PW = 8;
  localparam int CW = 8;
`ifdef SYNC_FRAME_PARITY_EN
  localparam int LEN = PW + 1;
`else
  localparam int LEN = PW;
`endif

  logic          clk = 1'b0;
  logic          rst, data, detected, out_ready;
  logic [PW-1:0] out_data;
  logic          out_valid, busy, overflow, parity_err;
  logic [CW-1:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit            m_cap;
  bit            bit_q[$];
  logic [PW-1:0] m_data;
  logic          m_valid, m_ovf, m_perr;
  logic [CW-1:0] m_count;

  sync_frame_capture #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .detected   (detected),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_count(frame_count),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, and return 1ns after the edge.
  task automatic cycle(input logic r, input logic d, input logic det, input logic rdy);
    logic          xfer;
    logic [PW-1:0] w;
    logic          p;
    rst = r; data = d; detected = det; out_ready = rdy;
    xfer = 1'b0; w = '0; p = 1'b0;
    if (r) begin
      m_cap = 0; bit_q.delete();
      m_data = '0; m_valid = 0; m_count = '0; m_ovf = 0; m_perr = 0;
    end else begin
      if (m_cap) bit_q.push_back(d);
      else if (det) begin
        m_cap = 1; bit_q.delete(); bit_q.push_back(d);
      end
      if (m_cap && bit_q.size() == LEN) begin
        xfer = 1'b1; m_cap = 0;
        for (int i = 0; i < PW; i++) w = {w[PW-2:0], bit_q[i]};
`ifdef SYNC_FRAME_PARITY_EN
        for (int i = 0; i < LEN; i++) p = p ^ bit_q[i];
`endif
      end
      if (xfer && (!m_valid || rdy)) begin
        m_data = w; m_valid = 1; m_count = m_count + 1'b1; m_perr = p;
      end else if (xfer) begin
        m_ovf = 1;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Optional sync prefix, then payload with detected on bit 0 (plus det_mask bits).
  task automatic send_frame(input logic [PW-1:0] payload, input logic rdy, input logic prefix,
                            input logic [PW-1:0] det_mask, input logic flip_par);
    logic [4:0] pat;
    pat = SYNC_PATTERN;
    if (prefix)
      for (int i = 0; i < 5; i++) cycle(1'b0, pat[4-i], 1'b0, rdy);
    for (int i = 0; i < PW; i++)
      cycle(1'b0, payload[PW-1-i], (i == 0) || det_mask[i], rdy);
`ifdef SYNC_FRAME_PARITY_EN
    cycle(1'b0, (^payload) ^ flip_par, 1'b0, rdy);
`else
    if (flip_par) cycle(1'b0, 1'b0, 1'b0, rdy);
`endif
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data: got %h want 00", out_data); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++; if (frame_count !== '0) begin n_fail++; $display("FAIL reset frame_count: got %0d want 0", frame_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset parity_err: got %b want 0", parity_err); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic out_valid: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL basic out_data: got %h want a5", out_data); end
    n_tests++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL basic frame_count: got %0d want 1", frame_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic busy: got %b want 0", busy); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic valid_drop: got %b want 0", out_valid); end
    $display("[TB] test_basic done: word %h", out_data);
  endtask

  task automatic test_pattern_in_payload();
    do_reset();
    send_frame(8'h5A, 1'b1, 1'b1, 8'b0011_1100, 1'b0);
    n_tests++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL inpay out_data: got %h want 5a", out_data); end
    n_tests++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL inpay frame_count: got %0d want 1", frame_count); end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL inpay later_count: got %0d want 1", frame_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL inpay busy: got %b want 0", busy); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inpay out_valid: got %b want 0", out_valid); end
    $display("[TB] test_pattern_in_payload done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h3C, 1'b1, 1'b1, 8'h00, 1'b0);
    n_tests++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL b2b first_data: got %h want 3c", out_data); end
    n_tests++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL b2b first_count: got %0d want 1", frame_count); end
    send_frame(8'h96, 1'b1, 1'b0, 8'h00, 1'b0);
    n_tests++; if (out_data !== 8'h96) begin n_fail++; $display("FAIL b2b second_data: got %h want 96", out_data); end
    n_tests++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL b2b second_count: got %0d want 2", frame_count); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b valid: got %b want 1", out_valid); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_backpressure();
    do_reset();
    send_frame(8'h11, 1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp early_overflow: got %b want 0", overflow); end
    send_frame(8'h22, 1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL bp held_data: got %h want 11", out_data); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp overflow: got %b want 1", overflow); end
    n_tests++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL bp frame_count: got %0d want 1", frame_count); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp valid_held: got %b want 1", out_valid); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp valid_clear: got %b want 0", out_valid); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp overflow_sticky: got %b want 1", overflow); end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_reset_mid_capture();
    logic [PW-1:0] w;
    logic [4:0]    pat;
    do_reset();
    w = 8'hC3; pat = SYNC_PATTERN;
    for (int i = 0; i < 5; i++) cycle(1'b0, pat[4-i], 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, w[PW-1-i], i == 0, 1'b1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst busy_before: got %b want 1", busy); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++; if ({out_data, out_valid, busy, frame_count, overflow, parity_err} !== '0)
      begin n_fail++; $display("FAIL midrst outputs: data=%h valid=%b busy=%b cnt=%0d ovf=%b perr=%b want all 0",
                               out_data, out_valid, busy, frame_count, overflow, parity_err); end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst no_emit: got %b want 0", out_valid); end
    send_frame(8'hC3, 1'b1, 1'b1, 8'h00, 1'b0);
    n_tests++; if (out_data !== 8'hC3) begin n_fail++; $display("FAIL midrst data: got %h want c3", out_data); end
    n_tests++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL midrst count: got %0d want 1", frame_count); end
    $display("[TB] test_reset_mid_capture done");
  endtask

`ifdef SYNC_FRAME_PARITY_EN
  task automatic test_parity();
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity good: got %b want 0", parity_err); end
    n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL parity good_data: got %h want a5", out_data); end
    send_frame(8'hA5, 1'b1, 1'b1, 8'h00, 1'b1);
    n_tests++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity bad: got %b want 1", parity_err); end
    n_tests++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL parity count: got %0d want 2", frame_count); end
    $display("[TB] test_parity done");
  endtask
`endif

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      cycle(c == 4000, 1'($urandom % 2), ($urandom % 3) == 0, ($urandom % 5) != 0);
      n_tests++;
      if ({out_data, out_valid, busy, frame_count, overflow, parity_err} !==
          {m_data, m_valid, m_cap, m_count, m_ovf, m_perr}) begin
        n_fail++; errs++;
        if (errs <= 20)
          $display("FAIL random cycle %0d: got data=%h valid=%b busy=%b cnt=%0d ovf=%b perr=%b want data=%h valid=%b busy=%b cnt=%0d ovf=%b perr=%b",
                   c, out_data, out_valid, busy, frame_count, overflow, parity_err,
                   m_data, m_valid, m_cap, m_count, m_ovf, m_perr);
      end
    end
    $display("[TB] test_random done: final frame_count %0d", frame_count);
  endtask

  initial begin
    rst = 1'b1; data = 1'b0; detected = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_pattern_in_payload();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_capture();
`ifdef SYNC_FRAME_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_frame_capture.md
Name: sync_frame_capture

Overview:
- Sits directly downstream of the 10110 sync-pattern detector (Moore, overlapping).
- Shares the detector's serial `data` input and consumes its `detected` flag.
- On a detection, captures the next PAYLOAD_W serial bits into a parallel word and presents the word on a valid/ready output.
- Counts frames and flags overflow when the consumer stalls.

Parameters:
- PAYLOAD_W, 8, payload bits captured per frame (2..32).
- CNT_W, 8, width of the frame counter (wraps).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- data  input  1  serial bit stream; the same signal the detector samples.
- detected  input  1  detector output; high for one or more cycles, in the cycle after the last pattern bit was sampled.
- out_data  output  PAYLOAD_W  captured word; first received bit is the MSB.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- busy  output  1  capture in progress.
- frame_count  output  CNT_W  completed frames delivered to the output register; wraps modulo 2^CNT_W.
- overflow  output  1  sticky; a completed frame was dropped.
- parity_err  output  1  parity result for the current word; see Optional Feature.

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, frame_count=0, overflow=0, parity_err=0, FSM=IDLE, bit counter=0.
  - Reset mid-capture abandons the partial word; nothing is emitted.
- FSM states: IDLE, CAPTURE.
- IDLE:
  - If detected=1, the data value in that same cycle is payload bit 0 (MSB).
  - Shift it into the shift register, set bit counter=1, go to CAPTURE, busy=1 from the next cycle.
  - If detected=0, stay in IDLE.
- CAPTURE:
  - Each cycle, shift data in (shreg = {shreg[PAYLOAD_W-2:0], data}) and increment the counter.
  - detected is ignored; patterns inside the payload do not restart capture.
  - In the cycle the counter reaches PAYLOAD_W-1, the last bit is sampled.
  - Next cycle: FSM=IDLE, busy=0, and the word is transferred to the output stage.
- Timing: detected seen at cycle T → bits sampled at T..T+PAYLOAD_W-1 → out_valid=1 at T+PAYLOAD_W.
  - A new detected at T+PAYLOAD_W (back in IDLE) starts the next frame with no gap.
- Output stage (one-word register):
  - Transfer when out_valid=0, or when out_valid && out_ready in the transfer cycle.
  - Transfer loads out_data, sets out_valid=1, and increments frame_count.
  - If out_valid=1 && out_ready=0 at transfer: the new word is dropped, overflow←1, frame_count unchanged, out_data unchanged.
  - Handshake: out_data stable while out_valid && !out_ready.
  - out_valid clears the cycle after acceptance unless a transfer coincides, in which case it stays 1.
- overflow clears only on rst.
- frame_count wraps from 2^CNT_W-1 to 0 without any flag.

Optional Feature:
- Macro: SYNC_FRAME_PARITY_EN.
- Defined:
  - Capture PAYLOAD_W+1 bits; the extra final bit is an even-parity bit over the payload.
  - Latency becomes PAYLOAD_W+1.
  - parity_err loads with the output word: 1 if the XOR of payload and parity bit is 1.
  - The word is still delivered.
- Undefined: parity_err is tied to 0 and capture length is PAYLOAD_W.

Decomposition:
- Package sync_frame_pkg holds:
  - FSM state typedef (IDLE, CAPTURE).
  - Default PAYLOAD_W/CNT_W constants.
  - The sync pattern constant 5'b10110 for benches.
- One sub-module: sync_frame_outreg, the one-word output register with valid/ready, overflow detect and frame counter.
- The capture FSM and shift register stay in the top.

Test Plan:
- Basic frame: stream 1,0,1,1,0 then 1,0,1,0,0,1,0,1 with out_ready=1 → out_data=0xA5, out_valid=1 at T+8 for 1 cycle, frame_count=1.
- Pattern inside payload: payload 0x5A, whose bit sequence contains 10110 overlapping, with detected pulsing mid-capture → exactly one word 0x5A, no restart.
- Back-to-back: detected high again at T+8 → second word captured with zero idle cycles, frame_count=2.
- Backpressure: out_ready=0 across two frames 0x11, 0x22 → out_data stays 0x11, overflow=1, frame_count=1; raising out_ready clears out_valid next cycle.
- Reset mid-capture: rst after 4 payload bits → all outputs 0; a later full frame 0xC3 is captured correctly.
- With SYNC_FRAME_PARITY_EN: payload 0xA5 with parity bit 0 → parity_err=0; parity bit 1 → parity_err=1, word still delivered.
